// File: rtl/ex_operand_sched.sv
// Operand scheduler between ID and EX: load-use stall detection, forwarding selects and a one-slot skid into EX.
// Optional STALL-cycle counter output is built when EX_OPERAND_SCHED_STALL_CNT_EN is defined.
module ex_operand_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_alusrc,
  input  logic        id_uses_rt,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwrite,
  input  logic        mem_regwrite,
  input  logic [4:0]  mem_rd,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic        alusrc,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
`ifdef EX_OPERAND_SCHED_STALL_CNT_EN
  output logic [15:0] stall_cnt,
`endif
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  state_t     state;
  logic       ex_hit_rs;
  logic       ex_hit_rt;
  logic       hazard;
  logic       slot_free;
  logic       accept;
  logic [1:0] fwd_a_d;
  logic [1:0] fwd_b_d;

  // Handshake: an instruction moves from ID when id_valid && id_ready on a rising edge;
  // the EX slot empties when ex_valid && ex_ready, and that same cycle may refill it.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    logic [1:0] sel;
    sel = FWD_RF;
    if (ex_regwrite && (ex_rd != 5'd0) && (ex_rd == src))
      sel = FWD_MEM;
    else if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == src))
      sel = FWD_WB;
    return sel;
  endfunction

  always_comb begin
    ex_hit_rs = (ex_rd != 5'd0) && (ex_rd == id_rs);
    ex_hit_rt = (ex_rd != 5'd0) && (ex_rd == id_rt) && id_uses_rt;
    hazard    = id_valid && ex_memread && (ex_hit_rs || ex_hit_rt);
    slot_free = !ex_valid || ex_ready;
    id_ready  = !hazard && slot_free;
    accept    = id_valid && id_ready;
    fwd_a_d   = fwd_sel(id_rs);
    fwd_b_d   = id_uses_rt ? fwd_sel(id_rt) : FWD_RF;
  end

  assign dbg_state = state;

  // A stalled instruction is simply re-evaluated from live inputs once the load has moved on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ex_valid <= 1'b0;
      alusrc   <= 1'b0;
      fwd_a    <= FWD_RF;
      fwd_b    <= FWD_RF;
    end else begin
      case (state)
        IDLE, STALL, ISSUE: begin
          if (accept) begin
            state    <= ISSUE;
            ex_valid <= 1'b1;
            alusrc   <= id_alusrc;
            fwd_a    <= fwd_a_d;
            fwd_b    <= fwd_b_d;
          end else if (slot_free) begin
            state    <= hazard ? STALL : IDLE;
            ex_valid <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          ex_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef EX_OPERAND_SCHED_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= 16'd0;
    else if ((state == STALL) && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: doc/ex_operand_sched.md
EX_OPERAND_SCHED -- requirements
Module: ex_operand_sched

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port id_valid, input, 1 bit: ID stage presents an instruction.
REQ-004 SHALL have port id_ready, output, 1 bit: block accepts the presented instruction this cycle.
REQ-005 SHALL have ports id_rs and id_rt, inputs, 5 bits each: source register numbers.
REQ-006 SHALL have port id_alusrc, input, 1 bit: instruction's second ALU operand is the sign-extended immediate.
REQ-007 SHALL have port id_uses_rt, input, 1 bit: instruction reads rt (ALU operand or store data).
REQ-008 SHALL have ports ex_memread, input, 1 bit, and ex_rd, input, 5 bits: load flag and destination of the instruction now in EX.
REQ-009 SHALL have ports ex_regwrite, input, 1 bit, and mem_regwrite, input, 1 bit: register-write flags of the instructions now in EX and EX/MEM.
REQ-010 SHALL have port mem_rd, input, 5 bits: destination of the instruction now in EX/MEM.
REQ-011 SHALL have port ex_valid, output, 1 bit: registered operand controls are valid for EX.
REQ-012 SHALL have port ex_ready, input, 1 bit: EX consumes the controls this cycle.
REQ-013 SHALL have port alusrc, output, 1 bit: registered select for the ALU second-operand mux (0 = rdata2, 1 = s_extendout).
REQ-014 SHALL have ports fwd_a and fwd_b, outputs, 2 bits each: registered forwarding selects (00 register file, 01 MEM/WB, 10 EX/MEM, 11 unused).

Function
REQ-015 SHALL implement the FSM states IDLE (ex_valid=0), ISSUE (ex_valid=1) and STALL (ex_valid=0; a bubble).
REQ-016 SHALL flag a hazard when id_valid=1, ex_memread=1, ex_rd!=0, and ex_rd equals id_rs, or ex_rd equals id_rt with id_uses_rt=1.
REQ-017 SHALL drive id_ready=1 only when there is no hazard and the output slot is free (ex_valid=0 or ex_ready=1); id_ready is combinational.
REQ-018 SHALL, on accept (id_valid and id_ready), register alusrc=id_alusrc, register fwd_a and fwd_b, and enter ISSUE on the next edge.
REQ-019 SHALL set fwd_a=10 if ex_regwrite=1, ex_rd!=0 and ex_rd==id_rs; else 01 if mem_regwrite=1, mem_rd!=0 and mem_rd==id_rs; else 00. EX match has priority.
REQ-020 SHALL compute fwd_b by the same rule using id_rt, and force fwd_b=00 when id_uses_rt=0.
REQ-021 SHALL, on a hazard while the output slot is free, enter STALL for exactly one cycle, then re-evaluate from the then-current inputs; the load's data then forwards as 01.
REQ-022 SHALL, in ISSUE with ex_ready=0, hold ex_valid, alusrc, fwd_a and fwd_b stable and keep id_ready=0.
REQ-023 SHALL, in ISSUE with ex_ready=1 and no new accept, go to IDLE; with a new accept, stay in ISSUE with the new values and no bubble.
REQ-024 SHALL treat register 0 as never matching for hazard or forwarding purposes.
REQ-025 SHALL have a latency of one cycle from accept to ex_valid=1, and zero cycles from ex_ready to slot free.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force state=IDLE, ex_valid=0, alusrc=0, fwd_a=00, fwd_b=00 and stall_cnt=0 (if present).
REQ-027 SHALL abandon any pending stall or held instruction on reset mid-operation; the first accept after deassertion follows REQ-017.

Configuration
REQ-028 SHALL, when macro EX_OPERAND_SCHED_STALL_CNT_EN is defined, add output stall_cnt (16 bits) that counts cycles spent in STALL, saturates at 16'hFFFF and clears on reset.
REQ-029 SHALL, when EX_OPERAND_SCHED_STALL_CNT_EN is undefined, omit the stall_cnt port and its logic; all other behaviour is identical.

Verification
REQ-030 SHALL cover: id_valid=1, id_rs=3, id_alusrc=1, no matches, ex_ready=1 -> next cycle ex_valid=1, alusrc=1, fwd_a=00, fwd_b=00.
REQ-031 SHALL cover: ex_regwrite=1, ex_rd=5, mem_regwrite=1, mem_rd=5, id_rs=5 -> fwd_a=10 (EX/MEM priority).
REQ-032 SHALL cover: ex_memread=1, ex_rd=7, id_rt=7, id_uses_rt=1 -> id_ready=0, one STALL cycle, then with mem_rd=7 and mem_regwrite=1: accept, fwd_b=01, stall_cnt=1 (if enabled).
REQ-033 SHALL cover: ISSUE with ex_ready=0 for 3 cycles -> outputs held, id_ready=0; ex_ready=1 with a new id_valid -> back-to-back issue, no bubble.
REQ-034 SHALL cover: id_rs=0 with ex_rd=0 and ex_regwrite=1 or ex_memread=1 -> no stall, fwd_a=00.
REQ-035 SHALL cover: rst_n asserted during STALL -> outputs zero immediately; after release, idle until the next id_valid.
